// File: rtl/systolic_input_skew.sv
// Input skew feeder for the 2x2 systolic array: re-times one activation row per
// cycle into a diagonal wavefront and frames each tile with switch/done pulses.
module systolic_input_skew #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] ub_row_count_in,
  input  logic               ub_row_count_valid_in,
  input  logic [DATA_W-1:0]  ub_data_in_1,
  input  logic [DATA_W-1:0]  ub_data_in_2,
  input  logic               ub_valid_in,
  output logic               ub_ready_out,
  output logic [DATA_W-1:0]  sys_data_out_1x,
  output logic [DATA_W-1:0]  sys_data_out_2x,
  output logic               sys_start_out,
  output logic               sys_valid_2x_out,
  output logic               sys_switch_out,
  output logic               busy_out,
  output logic               done_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DRAIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   rows_m_q, rows_m_d;
  logic [COUNT_W-1:0]   rows_acc_q, rows_acc_d;
  logic                 drain_q, drain_d;
  logic [DATA_W-1:0]    lane1_q, lane1_d;
  logic                 lane1_v_q, lane1_v_d;
  logic [DATA_W-1:0]    stage_q, stage_d;
  logic                 stage_v_q, stage_v_d;
  logic [DATA_W-1:0]    lane2_q, lane2_d;
  logic                 lane2_v_q, lane2_v_d;
  logic                 switch_q, switch_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic [COUNT_W-1:0]   rows_acc_inc;

  // The array never stalls, so readiness depends on state alone.
  assign ub_ready_out = (state_q == S_STREAM);
  assign accept       = ub_ready_out & ub_valid_in;
  assign rows_acc_inc = COUNT_W'(rows_acc_q + 1'b1);

  // Next-state and datapath: lane 2 always shifts from the stage register,
  // lane 1 and the stage load only on accept and otherwise fall to zero bubbles.
  always_comb begin
    state_d    = state_q;
    rows_m_d   = rows_m_q;
    rows_acc_d = rows_acc_q;
    drain_d    = drain_q;
    lane1_d    = '0;
    lane1_v_d  = 1'b0;
    stage_d    = '0;
    stage_v_d  = 1'b0;
    lane2_d    = stage_q;
    lane2_v_d  = stage_v_q;
    switch_d   = 1'b0;
    done_d     = 1'b0;

    if (accept) begin
      lane1_d    = ub_data_in_1;
      lane1_v_d  = 1'b1;
      stage_d    = ub_data_in_2;
      stage_v_d  = 1'b1;
      rows_acc_d = rows_acc_inc;
      switch_d   = (rows_acc_q == '0);
    end

    unique case (state_q)
      S_IDLE: begin
        if (ub_row_count_valid_in && (ub_row_count_in != '0)) begin
          rows_m_d   = ub_row_count_in;
          rows_acc_d = '0;
          state_d    = S_STREAM;
        end
      end
      S_STREAM: begin
        if (accept && (rows_acc_inc == rows_m_q)) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // Two edges: lane 2 takes the last element, then it empties.
        if (drain_q) begin
          state_d = S_IDLE;
          drain_d = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        drain_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rows_m_q   <= '0;
      rows_acc_q <= '0;
      drain_q    <= 1'b0;
      lane1_q    <= '0;
      lane1_v_q  <= 1'b0;
      stage_q    <= '0;
      stage_v_q  <= 1'b0;
      lane2_q    <= '0;
      lane2_v_q  <= 1'b0;
      switch_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_m_q   <= rows_m_d;
      rows_acc_q <= rows_acc_d;
      drain_q    <= drain_d;
      lane1_q    <= lane1_d;
      lane1_v_q  <= lane1_v_d;
      stage_q    <= stage_d;
      stage_v_q  <= stage_v_d;
      lane2_q    <= lane2_d;
      lane2_v_q  <= lane2_v_d;
      switch_q   <= switch_d;
      done_q     <= done_d;
    end
  end

  assign sys_data_out_1x  = lane1_q;
  assign sys_data_out_2x  = lane2_q;
  assign sys_start_out    = lane1_v_q;
  assign sys_valid_2x_out = lane2_v_q;
  assign sys_switch_out   = switch_q;
  assign busy_out         = (state_q != S_IDLE);
  assign done_out         = done_q;

endmodule

// File: doc/systolic_input_skew.md
Name: systolic_input_skew

Overview:
Upstream feeder for the 2x2 systolic array. Accepts one activation row (both K-elements of a row of A, Q8.8 signed) per cycle from the unified-buffer read path over a valid/ready handshake. Re-times the row into the diagonal wavefront the array expects: lane 1 to the array's row-1 input, lane 2 one cycle later to the row-2 input. Generates sys_start and a one-cycle weight-switch pulse per tile, and signals tile completion.

Parameters:
DATA_W, 16, activation width (Q8.8 signed fixed point)
COUNT_W, 16, width of tile row counter and row-count input

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
ub_row_count_in  input  COUNT_W  number of rows M in next tile
ub_row_count_valid_in  input  1  latch ub_row_count_in (sampled only in IDLE)
ub_data_in_1  input  DATA_W  A[i][0]
ub_data_in_2  input  DATA_W  A[i][1]
ub_valid_in  input  1  row valid
ub_ready_out  output  1  feeder can accept a row this cycle
sys_data_out_1x  output  DATA_W  to systolic sys_data_in_1x
sys_data_out_2x  output  DATA_W  to systolic sys_data_in_2x
sys_start_out  output  1  lane-1 data valid (drives sys_start)
sys_valid_2x_out  output  1  lane-2 data valid
sys_switch_out  output  1  one-cycle pulse with first lane-1 element of tile
busy_out  output  1  state != IDLE
done_out  output  1  one-cycle pulse after last lane-2 element leaves

Behaviour:
- Reset (async, rst=0): state IDLE; all outputs 0; all data/valid/stage regs 0; row counter and latched M cleared. Reset mid-tile aborts it; no done pulse.
- States: IDLE, STREAM, DRAIN.
- IDLE: ub_ready_out=0. If ub_row_count_valid_in=1 and ub_row_count_in!=0: latch M, rows_accepted=0, go STREAM next edge. M=0 ignored, stay IDLE. ub_row_count_valid_in ignored outside IDLE.
- STREAM: ub_ready_out=1 (combinational from state only; the array never stalls). Accept = ub_valid_in & ub_ready_out.
- On accept at edge E: lane1 reg <= ub_data_in_1, lane1 valid <= 1; stage reg <= ub_data_in_2, stage valid <= 1; rows_accepted++.
- Every edge: lane2 reg <= stage reg, lane2 valid <= stage valid. Without accept: lane1 valid <= 0, stage valid <= 0.
- Latency: ub_data_in_1 appears on sys_data_out_1x 1 cycle after accept. ub_data_in_2 appears on sys_data_out_2x 2 cycles after accept.
- Invalid lanes drive data 0 (bubbles are zeros with valid low). Input gaps propagate as bubbles, preserving skew.
- sys_start_out = lane1 valid. sys_valid_2x_out = lane2 valid.
- sys_switch_out is registered. It is 1 in the same cycle the first row of the tile is on lane 1, and 0 otherwise.
- When accept makes rows_accepted == M: next state DRAIN (ub_ready_out=0 from that edge).
- DRAIN: lasts two edges. After the first, lane 2 carries the last element and lane 1 is idle. At the second edge, state goes IDLE and done_out=1 for that following cycle only.
- A new tile can be latched in the IDLE cycle where done_out=1. Minimum gap between tiles: 1 IDLE cycle.
- Counter does not wrap; M <= 2^COUNT_W-1.
- No arithmetic on data; values pass bit-exact.

Test Plan:
- Reset: assert rst=0 mid-stream -> all outputs 0 immediately (before next edge), state IDLE, no done pulse after release.
- Basic tile M=2, rows (0x0100,0x0200),(0x0500,0x0600) accepted at E0,E1.
  - After E0: 1x=0x0100, start=1, switch=1.
  - After E1: 1x=0x0500, 2x=0x0200, switch=0.
  - After E2: 1x=0, start=0, 2x=0x0600.
  - After E3: valid_2x=0, done_out=1 for one cycle, ready=0 from E1 onward.
- Bubble: M=2, ub_valid_in low one cycle between rows -> lane-1 zero bubble (start=0) for one cycle, then the same bubble on lane 2 one cycle later; done delayed by 1 cycle.
- Length control: ub_row_count_in=0 with valid -> stays IDLE, ready=0. ub_row_count_valid_in pulsed during STREAM -> ignored, tile still ends after original M.
- Back-to-back: M=3 tile, then new M=1 latched in done cycle -> second tile switch pulse on its first row, outputs bit-exact (e.g. 0x8000, 0x7FFF pass unchanged).
- Negative data: row (0xFF00,0xFE80) -> 1x=0xFF00, 2x=0xFE80 one cycle later, no sign alteration.
